// File: rtl/ctrl_unit_if.sv
// rtl/ctrl_unit_if.sv - instruction word in, decoded control strobes out
interface ctrl_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] inst;
  logic [2:0]      alu_op;
  logic            alu_imm;
  logic            alu_sub;
  logic            alu_sra;
  logic            rd_w;
  logic            ld_upper;
  logic            add_pc;
  logic            jmp_reg;
  logic            is_branch;
  logic            is_jmp;
  logic            is_load;
  logic            is_store;
  logic            is_fence;
  logic            is_fencei;
  logic            illegal;
  logic            illegal_seen;

  modport master (
    output inst,
    input  alu_op, alu_imm, alu_sub, alu_sra, rd_w, ld_upper, add_pc,
           jmp_reg, is_branch, is_jmp, is_load, is_store, is_fence,
           is_fencei, illegal, illegal_seen
  );

  modport slave (
    input  inst,
    output alu_op, alu_imm, alu_sub, alu_sra, rd_w, ld_upper, add_pc,
           jmp_reg, is_branch, is_jmp, is_load, is_store, is_fence,
           is_fencei, illegal, illegal_seen
  );
endinterface

// File: rtl/ctrl_unit.sv
// rtl/ctrl_unit.sv - RV32I zero-latency decoder with sticky illegal flag
module ctrl_unit #(
  parameter int XLEN = 32
) (
  input logic        clk,
  input logic        rst,
  ctrl_unit_if.slave bus
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [XLEN-1:0] inst_w;
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic            unused_inst_bits;

  assign inst_w           = bus.inst;
  assign opc              = inst_w[6:0];
  assign f3               = inst_w[14:12];
  assign f7               = inst_w[31:25];
  assign unused_inst_bits = ^{inst_w[24:15], inst_w[11:7]};

  logic [2:0] alu_op_d;
  logic       alu_imm_d, alu_sub_d, alu_sra_d, rd_w_d, ld_upper_d, add_pc_d;
  logic       jmp_reg_d, is_branch_d, is_jmp_d, is_load_d, is_store_d;
  logic       is_fence_d, is_fencei_d, ill;

  // Raw decode; illegality is resolved here and applied as a mask below.
  always_comb begin
    alu_op_d    = 3'b000;
    alu_imm_d   = 1'b0;
    alu_sub_d   = 1'b0;
    alu_sra_d   = 1'b0;
    rd_w_d      = 1'b0;
    ld_upper_d  = 1'b0;
    add_pc_d    = 1'b0;
    jmp_reg_d   = 1'b0;
    is_branch_d = 1'b0;
    is_jmp_d    = 1'b0;
    is_load_d   = 1'b0;
    is_store_d  = 1'b0;
    is_fence_d  = 1'b0;
    is_fencei_d = 1'b0;
    ill         = 1'b0;
    case (opc)
      OPC_LUI: begin
        rd_w_d     = 1'b1;
        ld_upper_d = 1'b1;
      end
      OPC_AUIPC: begin
        rd_w_d   = 1'b1;
        add_pc_d = 1'b1;
      end
      OPC_JAL: begin
        rd_w_d   = 1'b1;
        is_jmp_d = 1'b1;
      end
      OPC_JALR: begin
        rd_w_d    = 1'b1;
        is_jmp_d  = 1'b1;
        jmp_reg_d = 1'b1;
        alu_imm_d = 1'b1;
        ill       = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        is_branch_d = 1'b1;
        ill         = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LOAD: begin
        rd_w_d    = 1'b1;
        alu_imm_d = 1'b1;
        is_load_d = 1'b1;
        ill       = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        alu_imm_d  = 1'b1;
        is_store_d = 1'b1;
        ill        = (f3[2] == 1'b1) || (f3 == 3'b011);
      end
      OPC_OPIMM: begin
        rd_w_d    = 1'b1;
        alu_imm_d = 1'b1;
        alu_op_d  = f3;
        // Only shifts carry a funct7; other OP-IMM upper bits are immediate.
        alu_sra_d = (f3 == 3'b101) && inst_w[30];
        if (f3 == 3'b001)
          ill = (f7 != F7_ZERO);
        else if (f3 == 3'b101)
          ill = (f7 != F7_ZERO) && (f7 != F7_ALT);
      end
      OPC_OP: begin
        rd_w_d    = 1'b1;
        alu_op_d  = f3;
        alu_sub_d = (f3 == 3'b000) && (f7 == F7_ALT);
        alu_sra_d = (f3 == 3'b101) && (f7 == F7_ALT);
        ill       = !((f7 == F7_ZERO) ||
                      ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OPC_MISC: begin
        if (f3 == 3'b000)
          is_fence_d = 1'b1;
        else if (f3 == 3'b001)
          is_fencei_d = 1'b1;
        else
          ill = 1'b1;
      end
      OPC_SYSTEM: begin
      end
      default: ill = 1'b1;
    endcase
  end

  assign bus.illegal   = ill;
  assign bus.alu_op    = ill ? 3'b000 : alu_op_d;
  assign bus.alu_imm   = alu_imm_d   & ~ill;
  assign bus.alu_sub   = alu_sub_d   & ~ill;
  assign bus.alu_sra   = alu_sra_d   & ~ill;
  assign bus.rd_w      = rd_w_d      & ~ill;
  assign bus.ld_upper  = ld_upper_d  & ~ill;
  assign bus.add_pc    = add_pc_d    & ~ill;
  assign bus.jmp_reg   = jmp_reg_d   & ~ill;
  assign bus.is_branch = is_branch_d & ~ill;
  assign bus.is_jmp    = is_jmp_d    & ~ill;
  assign bus.is_load   = is_load_d   & ~ill;
  assign bus.is_store  = is_store_d  & ~ill;
  assign bus.is_fence  = is_fence_d  & ~ill;
  assign bus.is_fencei = is_fencei_d & ~ill;

  logic illegal_seen_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      illegal_seen_q <= 1'b0;
    else if (ill)
      illegal_seen_q <= 1'b1;
  end

  assign bus.illegal_seen = illegal_seen_q;

endmodule

// File: tb/tb_ctrl_unit.sv
// tb/tb_ctrl_unit.sv - self-checking bench for ctrl_unit
module tb_ctrl_unit;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  ctrl_unit_if #(.XLEN(32)) bus ();

  ctrl_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [16:0] M_IMM = 17'h1 << 13;
  localparam logic [16:0] M_SUB = 17'h1 << 12;
  localparam logic [16:0] M_SRA = 17'h1 << 11;
  localparam logic [16:0] M_RD  = 17'h1 << 10;
  localparam logic [16:0] M_LU  = 17'h1 << 9;
  localparam logic [16:0] M_AP  = 17'h1 << 8;
  localparam logic [16:0] M_JR  = 17'h1 << 7;
  localparam logic [16:0] M_BR  = 17'h1 << 6;
  localparam logic [16:0] M_J   = 17'h1 << 5;
  localparam logic [16:0] M_LD  = 17'h1 << 4;
  localparam logic [16:0] M_ST  = 17'h1 << 3;
  localparam logic [16:0] M_F   = 17'h1 << 2;
  localparam logic [16:0] M_FI  = 17'h1 << 1;
  localparam logic [16:0] M_IL  = 17'h1;

  function automatic logic [16:0] op_field(input logic [2:0] op);
    return {op, 14'b0};
  endfunction

  function automatic logic [16:0] observed();
    return {bus.alu_op, bus.alu_imm, bus.alu_sub, bus.alu_sra, bus.rd_w,
            bus.ld_upper, bus.add_pc, bus.jmp_reg, bus.is_branch, bus.is_jmp,
            bus.is_load, bus.is_store, bus.is_fence, bus.is_fencei, bus.illegal};
  endfunction

  // Reference: legality first from the instruction-class rules, then strobes.
  function automatic logic [16:0] model(input logic [31:0] w);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        legal;
    logic [16:0] v;
    opc   = w[6:0];
    f3    = w[14:12];
    f7    = w[31:25];
    legal = 1'b0;
    v     = '0;
    case (opc)
      7'h37: begin legal = 1; v = M_RD | M_LU; end
      7'h17: begin legal = 1; v = M_RD | M_AP; end
      7'h6F: begin legal = 1; v = M_RD | M_J; end
      7'h67: begin legal = (f3 == 0); v = M_RD | M_J | M_JR | M_IMM; end
      7'h63: begin legal = f3 inside {0, 1, 4, 5, 6, 7}; v = M_BR; end
      7'h03: begin legal = f3 inside {0, 1, 2, 4, 5}; v = M_RD | M_IMM | M_LD; end
      7'h23: begin legal = f3 inside {0, 1, 2}; v = M_IMM | M_ST; end
      7'h13: begin
        legal = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 inside {0, 32}) : 1'b1;
        v = M_RD | M_IMM | op_field(f3) | ((f3 == 5 && w[30]) ? M_SRA : 17'h0);
      end
      7'h33: begin
        legal = (f7 == 0) || (f7 == 32 && f3 inside {0, 5});
        v = M_RD | op_field(f3);
        if (f7 == 32 && f3 == 0) v = v | M_SUB;
        if (f7 == 32 && f3 == 5) v = v | M_SRA;
      end
      7'h0F: begin
        legal = f3 inside {0, 1};
        v = (f3 == 0) ? M_F : M_FI;
      end
      7'h73: begin legal = 1; v = '0; end
      default: legal = 0;
    endcase
    return legal ? v : M_IL;
  endfunction

  logic [31:0] d_inst [0:30] = '{
    32'h00000037, 32'h00000017, 32'h0000006F, 32'h00000067,
    32'h00000063, 32'h00001063, 32'h00004063, 32'h00005063,
    32'h00006063, 32'h00007063, 32'h00002063,
    32'h00000003, 32'h00001003, 32'h00002003, 32'h00004003, 32'h00005003,
    32'h00000023, 32'h00001023, 32'h00002023,
    32'h00000013, 32'h00002013, 32'h00007013, 32'h40005013, 32'hFFF00013,
    32'h00000033, 32'h40000033, 32'h40005033, 32'h40001033,
    32'h0000000F, 32'h0000100F, 32'h00000073
  };

  logic [16:0] d_exp [0:30] = '{
    M_RD | M_LU, M_RD | M_AP, M_RD | M_J, M_RD | M_J | M_JR | M_IMM,
    M_BR, M_BR, M_BR, M_BR,
    M_BR, M_BR, M_IL,
    M_RD | M_IMM | M_LD, M_RD | M_IMM | M_LD, M_RD | M_IMM | M_LD,
    M_RD | M_IMM | M_LD, M_RD | M_IMM | M_LD,
    M_IMM | M_ST, M_IMM | M_ST, M_IMM | M_ST,
    M_RD | M_IMM, (17'h2 << 14) | M_RD | M_IMM, (17'h7 << 14) | M_RD | M_IMM,
    (17'h5 << 14) | M_RD | M_IMM | M_SRA, M_RD | M_IMM,
    M_RD, M_RD | M_SUB, (17'h5 << 14) | M_RD | M_SRA, M_IL,
    M_F, M_FI, 17'h0
  };

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.inst = 32'h00000000;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (bus.illegal_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_seen: got %b want 0", bus.illegal_seen);
    end
    n_vec++;
    if (bus.illegal !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_comb_illegal: got %b want 1", bus.illegal);
    end
    @(negedge clk);
    bus.inst = 32'h00000037;
    #1;
    n_vec++;
    if (observed() !== (M_RD | M_LU)) begin
      n_bad++;
      $display("FAIL reset_comb_lui: got %h want %h", observed(), M_RD | M_LU);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    for (int i = 0; i < 31; i++) begin
      bus.inst = d_inst[i];
      #2;
      n_vec++;
      if (observed() !== d_exp[i]) begin
        n_bad++;
        $display("FAIL directed[%0d] inst=%h: got %h want %h", i, d_inst[i], observed(), d_exp[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0]  opcs [0:10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    logic [31:0] w;
    logic [16:0] e;
    logic        seen_m;
    @(negedge clk);
    rst = 1'b1;
    bus.inst = 32'h00000013;
    @(negedge clk);
    rst = 1'b0;
    seen_m = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      w = $urandom;
      if ($urandom_range(0, 7) != 0) w[6:0] = opcs[$urandom_range(0, 10)];
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        default: ;
      endcase
      // Keep most of the run legal so the sticky flag is seen rising mid-run.
      if (i < 200 && model(w) == M_IL) w = 32'h00000013;
      bus.inst = w;
      e = model(w);
      #1;
      n_vec++;
      if (observed() !== e) begin
        n_bad++;
        $display("FAIL random[%0d] inst=%h: got %h want %h", i, w, observed(), e);
      end
      @(posedge clk);
      if (e[0]) seen_m = 1'b1;
      #1;
      n_vec++;
      if (bus.illegal_seen !== seen_m) begin
        n_bad++;
        $display("FAIL random_seen[%0d]: got %b want %b", i, bus.illegal_seen, seen_m);
      end
    end
  endtask

  task automatic test_flag_sequence();
    @(negedge clk);
    rst = 1'b1;
    bus.inst = 32'h00000013;
    #1;
    n_vec++;
    if (bus.illegal_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL flag_reset: got %b want 0", bus.illegal_seen);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.inst = 32'h00000000;
    #1;
    n_vec++;
    if (bus.illegal !== 1'b1) begin
      n_bad++;
      $display("FAIL flag_illegal: got %b want 1", bus.illegal);
    end
    n_vec++;
    if (bus.illegal_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL flag_before_edge: got %b want 0", bus.illegal_seen);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.illegal_seen !== 1'b1) begin
      n_bad++;
      $display("FAIL flag_set: got %b want 1", bus.illegal_seen);
    end
    @(negedge clk);
    bus.inst = 32'h00000013;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (bus.illegal_seen !== 1'b1) begin
      n_bad++;
      $display("FAIL flag_sticky: got %b want 1", bus.illegal_seen);
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.illegal_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL flag_async_clear: got %b want 0", bus.illegal_seen);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.illegal_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL flag_stays_clear: got %b want 0", bus.illegal_seen);
    end
  endtask

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    bus.inst = 32'h00000013;
    test_reset();
    test_directed();
    test_random();
    test_flag_sequence();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ctrl_unit.md
Name: ctrl_unit

Overview:
RV32I instruction decoder for the single-issue core. It sits between instruction fetch and the datapath. It turns the 32-bit instruction word into ALU, register-file, PC and memory control strobes, purely combinationally with zero latency. It also flags unsupported encodings, both combinationally (illegal) and via a sticky flag register (illegal_seen) on the core clock.

Parameters:
XLEN, 32, instruction/data width; only 32 supported.

Ports:
clk  input  1  core clock; used only by the illegal_seen register.
rst  input  1  asynchronous active-high reset.
inst  input  XLEN  instruction word under decode.
alu_op  output  3  ALU operation select (RV32I funct3 encoding).
alu_imm  output  1  ALU operand B is the immediate (otherwise rs2).
alu_sub  output  1  ALU subtracts (op 000).
alu_sra  output  1  shift-right is arithmetic (op 101).
rd_w  output  1  write rd.
ld_upper  output  1  LUI: rd <= U-immediate.
add_pc  output  1  AUIPC: rd <= PC + U-immediate.
jmp_reg  output  1  jump target is rs1 + imm (JALR).
is_branch  output  1  conditional branch.
is_jmp  output  1  unconditional jump; rd <= PC+4.
is_load  output  1  memory load.
is_store  output  1  memory store.
is_fence  output  1  FENCE.
is_fencei  output  1  FENCE.I.
illegal  output  1  current inst is not a supported encoding.
illegal_seen  output  1  sticky: an illegal inst was presented at a clk rising edge since reset.

Behaviour:
- Fields: opc=inst[6:0], f3=inst[14:12], f7=inst[31:25].
- All control outputs are combinational from inst, settle within the same cycle, and have no reset dependence.
- Default for every control output is 0. alu_op defaults to 000.
- LUI (0110111): rd_w, ld_upper.
- AUIPC (0010111): rd_w, add_pc.
- JAL (1101111): rd_w, is_jmp.
- JALR (1100111, f3=000): rd_w, is_jmp, jmp_reg, alu_imm, alu_op=000.
- BRANCH (1100011): is_branch. Legal only for f3 in {000,001,100,101,110,111}; rd_w=0.
- LOAD (0000011): rd_w, alu_imm, is_load, alu_op=000. Legal f3: {000,001,010,100,101}.
- STORE (0100011): alu_imm, is_store, alu_op=000, rd_w=0. Legal f3: {000,001,010}.
- OP-IMM (0010011): rd_w, alu_imm, alu_op=f3.
  - alu_sra=1 only when f3=101 and inst[30]=1.
  - alu_sub is never set for OP-IMM; addi with a negative immediate must not set it.
  - f3=001 requires f7=0000000; f3=101 requires f7 in {0000000,0100000}.
- OP (0110011): rd_w, alu_op=f3.
  - alu_sub=1 when f3=000 and f7=0100000.
  - alu_sra=1 when f3=101 and f7=0100000.
  - f7 must be 0000000, or 0100000 with f3 in {000,101}.
- MISC-MEM (0001111):
  - f3=000 gives is_fence.
  - f3=001 gives is_fencei.
  - rd_w=0 in both cases; other f3 is illegal.
- SYSTEM (1110011): decoded as a no-op. All outputs are 0 and illegal=0.
- Everything else, or inst[1:0]!=11, is illegal.
- When illegal=1, every other control output is forced to 0 (alu_op=000). No register write and no memory access.
- illegal_seen:
  - rst=1 clears it to 0 asynchronously and holds it at 0 while asserted.
  - Otherwise, at a clk rising edge with illegal=1, it sets to 1.
  - It stays set until the next reset.
- Reset value of illegal_seen is 0. Combinational outputs follow inst regardless of rst.

Test Plan:
- lui x0,0 (0x00000037) -> rd_w=1, ld_upper=1, all other strobes 0. auipc (0x00000017) -> rd_w=1, add_pc=1.
- jal (0x0000006F) -> rd_w=1, is_jmp=1, jmp_reg=0. jalr (0x00000067) -> rd_w, is_jmp, jmp_reg, alu_imm=1, alu_op=000.
- Branches beq..bgeu (0x63 with f3 000,001,100,101,110,111) -> is_branch=1 only. f3=010 -> illegal=1, all strobes 0.
- Loads lb/lh/lw/lbu/lhu -> rd_w, alu_imm, is_load, alu_op=000. Stores sb/sh/sw -> alu_imm, is_store, rd_w=0.
- ALU ops:
  - addi..andi -> alu_op=f3, alu_imm=1; srai (0x40005013) -> alu_op=101, alu_sra=1.
  - addi with imm=-1 (0xFFF00013) -> alu_sub=0.
  - add/sub (0x40000033) -> sub sets alu_sub; sra (0x40005033) sets alu_sra.
  - fence (0x0000000F) -> is_fence; fence.i (0x0000100F) -> is_fencei.
- Flag sequence:
  - Assert rst; illegal_seen=0.
  - Release rst; apply 0x00000000 and clock once -> illegal=1, illegal_seen=1.
  - Apply addi and clock -> illegal_seen stays 1.
  - Pulse rst mid-cycle (no clock edge) -> illegal_seen=0 immediately.
